// File: rtl/pc.sv
// rtl/pc.sv - program-counter register at the head of the fetch stage
//
// Captures the next-PC value from upstream on every rising clk edge and
// presents it as the current fetch address. One-cycle load latency and a
// synchronous reset to RESET_VALUE. There is no enable: stalls are made
// upstream by feeding PC_out back into PC_in.
//
// Optional feature macro: PC_ALIGN_EN
//   defined   - bits [1:0] of every loaded value (including RESET_VALUE)
//               are forced to 0, so PC_out is always word aligned.
//               Requires WIDTH >= 2.
//   undefined - PC_in is loaded bit-exact.
//
// Parameters:
//   WIDTH        bit width of PC_in / PC_out
//   RESET_VALUE  value loaded on reset (must fit in WIDTH bits)
//
// Ports:
//   clk     in   1      clock, all state updates on rising edge
//   reset   in   1      synchronous active-high reset, priority over load
//   PC_in   in   WIDTH  next program-counter value
//   PC_out  out  WIDTH  current program-counter value, registered

module pc #(
  parameter int unsigned            WIDTH       = 8,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PC_in,
  output logic [WIDTH-1:0] PC_out
);

`ifdef PC_ALIGN_EN
  // Clear the two byte-offset bits so every fetch address is a word address.
  localparam logic [WIDTH-1:0] LOAD_MASK = ~(WIDTH'(3));
`else
  localparam logic [WIDTH-1:0] LOAD_MASK = '1;
`endif

  localparam logic [WIDTH-1:0] RESET_LOAD = RESET_VALUE & LOAD_MASK;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;

  assign w_pc_next = PC_in & LOAD_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_LOAD;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Driven straight from the register: no combinational path from PC_in.
  assign PC_out = r_pc;

endmodule

// File: tb/tb_pc.sv
// tb/tb_pc.sv - scoreboard bench for the program-counter register

module tb_pc;

  localparam int unsigned W  = 8;
  localparam logic [W-1:0] RV = 8'd0;

  logic         clk;
  logic         reset;
  logic [W-1:0] PC_in;
  logic [W-1:0] PC_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;
  bit           held_valid = 0;
  bit           stim_done  = 0;

  pc #(
    .WIDTH       (W),
    .RESET_VALUE (RV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .PC_in  (PC_in),
    .PC_out (PC_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: after an edge the PC holds the reset address or the offered
  // address, rounded down to a multiple of 4 when alignment is enabled.
  function automatic logic [W-1:0] model(input bit rst, input logic [W-1:0] v);
    int unsigned x;
    x = rst ? int'(RV) : int'(v);
`ifdef PC_ALIGN_EN
    x = x - (x % 4);
`endif
    return W'(x);
  endfunction

  // Inputs are set between edges; exactly one expectation per rising edge.
  task automatic step(input bit rst, input logic [W-1:0] v);
    reset = rst;
    PC_in = v;
    exp_q.push_back(model(rst, v));
    @(negedge clk);
  endtask

  // PC_in wobbles before and after the edge; only the value at the edge counts.
  task automatic step_glitch();
    reset = 1'b0;
    PC_in = 8'd8;
    exp_q.push_back(model(1'b0, 8'd8));
    #1 PC_in = 8'd12;
    #1 PC_in = 8'd8;
    @(posedge clk);
    #2 PC_in = 8'd12;
    @(negedge clk);
  endtask

  // Monitor: one output per rising edge, compared shortly after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (PC_out !== e) begin
        n_fail++;
        $display("FAIL edge_value t=%0t actual=%0d required=%0d", $time, PC_out, e);
      end
      held       = e;
      held_valid = 1;
    end else if (!stim_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow t=%0t actual=%0d required=none", $time, PC_out);
    end
  end

  // Between edges PC_out must keep the value loaded at the last edge.
  always @(negedge clk) begin
    if (held_valid && !stim_done) begin
      n_checks++;
      if (PC_out !== held) begin
        n_fail++;
        $display("FAIL mid_cycle_hold t=%0t actual=%0d required=%0d", $time, PC_out, held);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // First edge with reset: PC_in is arbitrary.
    step(1'b1, W'($urandom));

    // Sequential loads
    step(1'b0, 8'd4);
    step(1'b0, 8'd16);
    step(1'b0, 8'd32);

    // Mid-cycle change
    step_glitch();

    // Reset priority then release with no bubble
    step(1'b0, 8'd32);
    step(1'b1, 8'd100);
    step(1'b0, 8'd100);

    // Boundary values
    step(1'b0, 8'd255);
    step(1'b0, 8'd0);

    // Misaligned value
    step(1'b0, 8'd7);
    step(1'b0, 8'd255);

    // Stall emulation: feed the expected current PC back in
    step(1'b0, 8'd40);
    step(1'b0, model(1'b0, 8'd40));
    step(1'b0, model(1'b0, 8'd40));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), W'($urandom));
    end

    stim_done = 1;
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
